// File: rtl/twiddle_seq_gen.sv
// Twiddle-factor source for one radix-2^2 SDF FFT stage: index sequencer, folded
// quarter-wave cosine ROM and a two-stage registered output with valid/ready handshake.
module twiddle_seq_gen #(
  parameter int LOG2N      = 6,
  parameter int STAGE      = 0,
  parameter int TW_WIDTH   = 16,
  parameter int CONTINUOUS = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                inverse,
  output logic                busy,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic [TW_WIDTH-1:0] tw_real,
  output logic [TW_WIDTH-1:0] tw_imag,
  output logic                tw_bypass,
  output logic                tw_last
);

  localparam int  N       = 1 << LOG2N;
  localparam int  MW      = LOG2N - 2 * STAGE;
  localparam int  M       = 1 << MW;
  localparam int  QW      = LOG2N - 2;
  localparam int  QUARTER = N / 4;
  localparam real PI      = 3.14159265358979323846;

  localparam logic [TW_WIDTH-1:0] MAXV = {1'b0, {(TW_WIDTH-1){1'b1}}};
  localparam logic [TW_WIDTH-1:0] MINV = {1'b1, {(TW_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    count_q, count_d;
  logic             inv_q, inv_d;
  logic             en, issue, lastIssue;

  logic [LOG2N-1:0] mulW, qExt, kProd, kIdx;

  logic             valid1_q, last1_q, byp1_q, inv1_q;
  logic [1:0]       quad1_q;
  logic [QW-1:0]    r1_q;

  logic [TW_WIDTH-1:0] romTable [0:QUARTER];
  logic [QW:0]         idxA, idxB;
  logic [TW_WIDTH-1:0] cA, cB, foldRe, foldIm;

  logic                tw_valid_q, last_q, byp_q;
  logic [TW_WIDTH-1:0] twReal_q, twImag_q;

  // Rounded, saturated cos(2*pi*j/N) in signed Q1.(TW_WIDTH-1), evaluated at elaboration.
  function automatic logic [TW_WIDTH-1:0] cosEntry(input int j);
    real x;
    int  v;
    x = $cos(2.0 * PI * real'(j) / real'(N)) * (2.0 ** (TW_WIDTH - 1));
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    if (v > int'(MAXV)) v = int'(MAXV);
    return TW_WIDTH'(v);
  endfunction

  // Full scale +max and -2^(W-1) swap on negation so neither wraps.
  function automatic logic [TW_WIDTH-1:0] satNeg(input logic [TW_WIDTH-1:0] x);
    if (x == MAXV)      return MINV;
    else if (x == MINV) return MAXV;
    else                return -x;
  endfunction

  for (genvar j = 0; j <= QUARTER; j++) begin : g_rom
    assign romTable[j] = cosEntry(j);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          inv_d   = inverse;
        end
      end
      RUN: begin
        if (en) begin
          if (lastIssue) begin
            count_d = '0;
            if (CONTINUOUS == 0) state_d = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en        = !tw_valid_q || tw_ready;
    issue     = (state_q == RUN) && en;
    lastIssue = (count_q == MW'(M - 1));
    busy      = (state_q == RUN) || valid1_q || tw_valid_q;
  end

  // k = (mul * q * 4^STAGE) mod N, with mul = {0,2,1,3}[p]; the mod is the natural LOG2N-bit wrap.
  always_comb begin
    case (count_q[MW-1:MW-2])
      2'd0:    mulW = LOG2N'(0);
      2'd1:    mulW = LOG2N'(2);
      2'd2:    mulW = LOG2N'(1);
      default: mulW = LOG2N'(3);
    endcase
    qExt  = LOG2N'(count_q) & LOG2N'(M / 4 - 1);
    kProd = mulW * qExt;
    kIdx  = kProd << (2 * STAGE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
      byp1_q   <= 1'b0;
      inv1_q   <= 1'b0;
      quad1_q  <= '0;
      r1_q     <= '0;
    end else if (en) begin
      valid1_q <= issue;
      if (issue) begin
        last1_q <= lastIssue;
        byp1_q  <= (kIdx == '0);
        inv1_q  <= inv_q;
        quad1_q <= kIdx[LOG2N-1:LOG2N-2];
        r1_q    <= kIdx[QW-1:0];
      end
    end
  end

  // Quadrant folding of the quarter-wave table; cB reads the mirrored entry C[N/4 - r].
  always_comb begin
    idxA = {1'b0, r1_q};
    idxB = (QW+1)'(QUARTER) - idxA;
    cA   = romTable[idxA];
    cB   = romTable[idxB];
    case (quad1_q)
      2'd0:    begin foldRe = cA;         foldIm = satNeg(cB); end
      2'd1:    begin foldRe = satNeg(cB); foldIm = satNeg(cA); end
      2'd2:    begin foldRe = satNeg(cA); foldIm = cB;         end
      default: begin foldRe = cB;         foldIm = cA;         end
    endcase
    if (inv1_q) foldIm = satNeg(foldIm);
    if (byp1_q) begin
      foldRe = '0;
      foldIm = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tw_valid_q <= 1'b0;
      last_q     <= 1'b0;
      byp_q      <= 1'b0;
      twReal_q   <= '0;
      twImag_q   <= '0;
    end else if (en) begin
      tw_valid_q <= valid1_q;
      last_q     <= valid1_q && last1_q;
      byp_q      <= valid1_q && byp1_q;
      twReal_q   <= valid1_q ? foldRe : '0;
      twImag_q   <= valid1_q ? foldIm : '0;
    end
  end

  assign tw_valid  = tw_valid_q;
  assign tw_last   = last_q;
  assign tw_bypass = byp_q;
  assign tw_real   = twReal_q;
  assign tw_imag   = twImag_q;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Bench for twiddle_seq_gen: two instances (N=64 stage 0 one-shot, N=64 stage 1 continuous),
// trig-based reference model feeding per-instance scoreboards drained by output monitors.
module tb_twiddle_seq_gen;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        byp;
    logic        last;
    int          m;
    bit          inv;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstA_n, startA, invA, readyA, busyA, validA, bypA, lastA;
  logic [15:0] reA, imA;
  logic        rstB_n, startB, invB, readyB, busyB, validB, bypB, lastB;
  logic [15:0] reB, imB;

  twiddle_seq_gen #(.LOG2N(6), .STAGE(0), .TW_WIDTH(16), .CONTINUOUS(0)) dutA (
    .clock(clock), .reset_n(rstA_n), .start(startA), .inverse(invA), .busy(busyA),
    .tw_valid(validA), .tw_ready(readyA), .tw_real(reA), .tw_imag(imA),
    .tw_bypass(bypA), .tw_last(lastA));

  twiddle_seq_gen #(.LOG2N(6), .STAGE(1), .TW_WIDTH(16), .CONTINUOUS(1)) dutB (
    .clock(clock), .reset_n(rstB_n), .start(startB), .inverse(invB), .busy(busyB),
    .tw_valid(validB), .tw_ready(readyB), .tw_real(reB), .tw_imag(imB),
    .tw_bypass(bypB), .tw_last(lastB));

  int   checks = 0;
  int   errors = 0;
  exp_t qA[$];
  exp_t qB[$];
  int   acceptedA = 0;
  int   acceptedB = 0;
  bit   randReadyA = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int toQ15(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x * 32768.0 + 0.5) : -$rtoi(-x * 32768.0 + 0.5);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Direct evaluation of W = exp(-j*2*pi*k/64) for index m of a frame at the given stage.
  function automatic exp_t refWord(input int stage, input int m, input bit inv);
    exp_t e;
    int   mulTab[4];
    int   mm, quarter, k, re, im;
    real  ang;
    mulTab  = '{0, 2, 1, 3};
    mm      = 64 >> (2 * stage);
    quarter = mm / 4;
    k       = (mulTab[m / quarter] * (m % quarter) * (1 << (2 * stage))) % 64;
    e.m = m; e.inv = inv; e.last = (m == mm - 1); e.byp = (k == 0);
    e.re = 16'h0; e.im = 16'h0;
    if (k != 0) begin
      ang = 2.0 * 3.14159265358979 * real'(k) / 64.0;
      re  = toQ15($cos(ang));
      im  = toQ15(-$sin(ang));
      if (inv) im = (im == -32768) ? 32767 : -im;
      e.re = 16'(re);
      e.im = 16'(im);
    end
    return e;
  endfunction

  // Start a frame on one instance; expectations are queued on the acceptance edge.
  task automatic applyStimulus(input bit sel, input bit inv, input int frames);
    @(posedge clock); #1;
    if (sel) begin startB = 1'b1; invB = inv; end
    else     begin startA = 1'b1; invA = inv; end
    @(posedge clock);
    for (int f = 0; f < frames; f++)
      for (int m = 0; m < (sel ? 16 : 64); m++) begin
        if (sel) qB.push_back(refWord(1, m, inv));
        else     qA.push_back(refWord(0, m, inv));
      end
    #1;
    startA = 1'b0; startB = 1'b0;
    @(negedge clock);
    checkOutput("latency T+0 valid", sel ? validB : validA, 0);
    @(negedge clock);
    checkOutput("latency T+1 valid", sel ? validB : validA, 0);
    @(negedge clock);
    checkOutput("latency T+2 valid", sel ? validB : validA, 1);
  endtask

  task automatic waitAccepted(input bit sel, input int target, input int bound);
    int n = 0;
    while ((sel ? acceptedB : acceptedA) < target) begin
      @(negedge clock); #1;
      n++;
      if (n > bound) begin
        checks++; errors++;
        $display("[TB] FAIL wait accepted: got %0d words, required %0d", sel ? acceptedB : acceptedA, target);
        return;
      end
    end
  endtask

  task automatic drainFrameA();
    waitAccepted(0, acceptedA + qA.size(), 2000);
    @(negedge clock);
    checkOutput("A busy/valid after last", {busyA, validA}, 2'b00);
  endtask

  initial begin : readyDriver
    forever begin
      @(posedge clock); #1;
      if (randReadyA) readyA = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitorA
    exp_t        e;
    logic [33:0] held;
    bit          stalled;
    stalled = 0;
    forever begin
      @(negedge clock);
      if (!rstA_n) begin
        stalled = 0;
      end else begin
        if (stalled) checkOutput("A stall hold", {validA, bypA, lastA, reA, imA}, {1'b1, held});
        stalled = 0;
        if (validA && readyA) begin
          if (qA.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL A extra word: got re=0x%h im=0x%h, required no word", reA, imA);
          end else begin
            e = qA.pop_front();
            acceptedA++;
            checkOutput($sformatf("A word m=%0d", e.m), {bypA, lastA, reA, imA}, {e.byp, e.last, e.re, e.im});
            if (!e.inv) begin
              if (e.m == 0)  checkOutput("A m0 bypass", {bypA, reA, imA}, {1'b1, 32'h0});
              if (e.m == 31) checkOutput("A m31", {reA, imA}, 32'h8276E707);
              if (e.m == 47) checkOutput("A m47", {reA, imA}, 32'h0C8C809E);
              if (e.m == 63) checkOutput("A m63 last", {lastA, reA, imA}, {1'b1, 32'hDAD87A7D});
            end else begin
              if (e.m == 31) checkOutput("A inv m31", {reA, imA}, 32'h827618F9);
              if (e.m == 24) checkOutput("A inv m24", {reA, imA}, 32'h00007FFF);
            end
          end
        end else if (validA) begin
          stalled = 1;
          held    = {bypA, lastA, reA, imA};
        end
      end
    end
  end

  initial begin : monitorB
    exp_t e;
    bit   expectNext;
    expectNext = 0;
    forever begin
      @(negedge clock);
      if (!rstB_n) begin
        expectNext = 0;
      end else begin
        if (expectNext) checkOutput("B no bubble after last", validB, 1);
        expectNext = 0;
        if (validB && readyB) begin
          if (qB.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL B extra word: got re=0x%h im=0x%h, required no word", reB, imB);
          end else begin
            e = qB.pop_front();
            acceptedB++;
            checkOutput($sformatf("B word m=%0d", e.m), {bypB, lastB, reB, imB}, {e.byp, e.last, e.re, e.im});
            if (e.m == 13) checkOutput("B m13", {reB, imB}, 32'h30FC89BE);
            if (e.m == 6)  checkOutput("B m6", {reB, imB}, 32'h00008000);
            if (e.m == 15) checkOutput("B m15 last", lastB, 1);
            if (e.last && qB.size() > 0) expectNext = 1;
          end
        end
      end
    end
  end

  initial begin : globalTimeout
    #500000;
    $display("[TB] FAIL global timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rstA_n = 1'b0; startA = 1'b0; invA = 1'b0; readyA = 1'b1;
    rstB_n = 1'b0; startB = 1'b0; invB = 1'b0; readyB = 1'b1;
    #12;
    checkOutput("A reset outputs", {busyA, validA, bypA, lastA, reA, imA}, 0);
    checkOutput("B reset outputs", {busyB, validB, bypB, lastB, reB, imB}, 0);
    @(negedge clock);
    rstA_n = 1'b1; rstB_n = 1'b1;
    $display("[TB] forward frame, stage 0");
    applyStimulus(0, 0, 1);
    drainFrameA();
    $display("[TB] inverse frame, stage 0");
    applyStimulus(0, 1, 1);
    drainFrameA();
    $display("[TB] forward frame with random backpressure");
    randReadyA = 1;
    applyStimulus(0, 0, 1);
    drainFrameA();
    randReadyA = 0;
    @(posedge clock); #1;
    readyA = 1'b1;
    $display("[TB] reset mid-frame, then restart");
    applyStimulus(0, 0, 1);
    waitAccepted(0, acceptedA + 20 - 3, 500);
    @(posedge clock); #2;
    rstA_n = 1'b0;
    #1;
    checkOutput("A async reset outputs", {busyA, validA, bypA, lastA, reA, imA}, 0);
    qA.delete();
    repeat (3) @(negedge clock);
    rstA_n = 1'b1;
    applyStimulus(0, 0, 1);
    drainFrameA();
    $display("[TB] continuous stage 1 with start pulse while running");
    applyStimulus(1, 0, 3);
    waitAccepted(1, 10, 500);
    @(posedge clock); #1;
    startB = 1'b1; invB = 1'b1;
    @(posedge clock); #1;
    startB = 1'b0; invB = 1'b0;
    waitAccepted(1, 44, 500);
    rstB_n = 1'b0;
    #1;
    checkOutput("B async reset outputs", {busyB, validB, bypB, lastB, reB, imB}, 0);
    qB.delete();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
